// File: rtl/demux1t4_32_buf.sv
// demux1t4_32_buf: registered 1-to-4 demultiplexer for DW-bit words.
// One valid/ready input stream is steered by in_sel to one of four
// output channels. Each channel has a one-deep holding register with its
// own valid/ready handshake.
// Optional feature macro: DEMUX1T4_CNT_EN. When it is defined, each
// channel gets a CW-bit counter of completed output transfers, readable
// through cnt_sel/cnt_out. When it is undefined, cnt_out is tied to zero.

module demux1t4_32_buf #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_sel,
   input  logic [DW-1:0] in_data,
   output logic [3:0]    o_valid,
   input  logic [3:0]    o_ready,
   output logic [DW-1:0] o_data0,
   output logic [DW-1:0] o_data1,
   output logic [DW-1:0] o_data2,
   output logic [DW-1:0] o_data3,
   input  logic [1:0]    cnt_sel,
   output logic [CW-1:0] cnt_out
);

   logic [DW-1:0] data_q [4];
   logic [DW-1:0] data_d [4];
   logic [3:0]    vld_q;
   logic [3:0]    vld_d;
   logic [3:0]    acc_s;
   logic [3:0]    drn_s;

   // The addressed channel alone decides readiness; a channel that drains this cycle can refill
   always_comb begin
      in_ready = ~vld_q[in_sel] | o_ready[in_sel];
   end

   // Per-channel accept/drain strobes and next-state of the holding registers
   always_comb begin
      acc_s = 4'b0000;
      drn_s = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         data_d[k] = data_q[k];
         vld_d[k]  = vld_q[k];
         acc_s[k]  = in_valid & in_ready & (in_sel == 2'(k));
         drn_s[k]  = vld_q[k] & o_ready[k];
         if (acc_s[k]) begin
            // Accept wins over drain: a same-cycle drain+fill keeps the channel full
            data_d[k] = in_data;
            vld_d[k]  = 1'b1;
         end else if (drn_s[k]) begin
            vld_d[k]  = 1'b0;
         end else begin
            vld_d[k]  = vld_q[k];
         end
      end
   end

   // Holding registers; reset clears every held word immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= {DW{1'b0}};
         end
         vld_q <= 4'b0000;
      end else begin
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= data_d[k];
         end
         vld_q <= vld_d;
      end
   end

   assign o_valid = vld_q;
   assign o_data0 = data_q[0];
   assign o_data1 = data_q[1];
   assign o_data2 = data_q[2];
   assign o_data3 = data_q[3];

`ifdef DEMUX1T4_CNT_EN
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];

   // Transfer counters advance on each completed output handshake and wrap naturally
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         if (drn_s[k]) begin
            cnt_d[k] = cnt_q[k] + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            cnt_d[k] = cnt_q[k];
         end
      end
   end

   // Counter registers; cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= {CW{1'b0}};
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   // Read-out mux over the counter registers
   always_comb begin
      case (cnt_sel)
         2'd0:    cnt_out = cnt_q[0];
         2'd1:    cnt_out = cnt_q[1];
         2'd2:    cnt_out = cnt_q[2];
         2'd3:    cnt_out = cnt_q[3];
         default: cnt_out = {CW{1'b0}};
      endcase
   end
`else
   logic unused_cnt_s;

   assign unused_cnt_s = ^{cnt_sel, drn_s};
   assign cnt_out      = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_demux1t4_32_buf.sv
// Directed self-checking bench for demux1t4_32_buf.
// Counter checks follow DEMUX1T4_CNT_EN: counts when defined, zero otherwise.

module tb_demux1t4_32_buf;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [31:0] in_data;
   logic [3:0]  o_valid;
   logic [3:0]  o_ready;
   logic [31:0] o_data0;
   logic [31:0] o_data1;
   logic [31:0] o_data2;
   logic [31:0] o_data3;
   logic [1:0]  cnt_sel;
   logic [15:0] cnt_out;

   int checks;
   int errors;

   demux1t4_32_buf dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_data0  (o_data0),
      .o_data1  (o_data1),
      .o_data2  (o_data2),
      .o_data3  (o_data3),
      .cnt_sel  (cnt_sel),
      .cnt_out  (cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 32'h0;
      o_ready = 4'b0000; cnt_sel = 2'd0;
      #12;
      checks++;
      if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", o_valid); end
      checks++;
      if ({o_data0, o_data1, o_data2, o_data3} !== 128'h0) begin
         errors++; $display("FAIL reset_data got %h %h %h %h exp 0", o_data0, o_data1, o_data2, o_data3);
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++;
      if (cnt_out !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", cnt_out); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF; o_ready = 4'b0000;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (o_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got %b exp 0100", o_valid); end
      checks++;
      if (o_data2 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data2 got %h exp deadbeef", o_data2); end
      checks++;
      if ({o_data0, o_data1, o_data3} !== 96'h0) begin
         errors++; $display("FAIL single_others got %h %h %h exp 0", o_data0, o_data1, o_data3);
      end
   endtask

   task automatic test_full_block();
      in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h12345678;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      tick();
      checks++;
      if (o_data2 !== 32'hDEADBEEF || o_valid !== 4'b0100) begin
         errors++; $display("FAIL full_hold got %h/%b exp deadbeef/0100", o_data2, o_valid);
      end
      in_sel = 2'd1; in_data = 32'hA5A5A5A5;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL other_ch_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (o_valid !== 4'b0110 || o_data1 !== 32'hA5A5A5A5 || o_data2 !== 32'hDEADBEEF) begin
         errors++; $display("FAIL other_ch_accept got %b %h %h exp 0110 a5a5a5a5 deadbeef", o_valid, o_data1, o_data2);
      end
      o_ready = 4'b0111;
      tick();
      o_ready = 4'b0000;
      checks++;
      if (o_valid !== 4'b0000) begin errors++; $display("FAIL drain_both got %b exp 0000", o_valid); end
   endtask

   task automatic test_stream();
      o_ready = 4'b0001;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_sel = 2'd0; in_data = 32'(i);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
         tick();
         checks++;
         if (o_data0 !== 32'(i) || o_valid[0] !== 1'b1) begin
            errors++; $display("FAIL stream_data[%0d] got %h/%b exp %h/1", i, o_data0, o_valid[0], 32'(i));
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (o_valid !== 4'b0000 || o_data0 !== 32'h8) begin
         errors++; $display("FAIL stream_end got %b/%h exp 0000/00000008", o_valid, o_data0);
      end
      o_ready = 4'b0000;
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h00000033; o_ready = 4'b0000;
      tick();
      o_ready = 4'b1000; in_data = 32'h00000055;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0; o_ready = 4'b0000;
      checks++;
      if (o_valid !== 4'b1000 || o_data3 !== 32'h00000055) begin
         errors++; $display("FAIL b2b_ch3 got %b/%h exp 1000/00000055", o_valid, o_data3);
      end
   endtask

   task automatic test_async_reset();
      // ch3 still holds 0x55; fill 0..2
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_sel = 2'(k); in_data = 32'hC0DE0000 + 32'(k);
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (o_valid !== 4'b1111 || o_data1 !== 32'hC0DE0001) begin
         errors++; $display("FAIL fill_all got %b/%h exp 1111/c0de0001", o_valid, o_data1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_valid !== 4'b0000 || {o_data0, o_data1, o_data2, o_data3} !== 128'h0) begin
         errors++; $display("FAIL async_reset got %b %h %h %h %h exp all 0", o_valid, o_data0, o_data1, o_data2, o_data3);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_counter();
`ifdef DEMUX1T4_CNT_EN
      o_ready = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h100 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      cnt_sel = 2'd1;
      #1;
      checks++;
      if (cnt_out !== 16'd3) begin errors++; $display("FAIL cnt_ch1 got %0d exp 3", cnt_out); end
      o_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
      for (int i = 0; i < 65536; i++) begin
         in_data = 32'(i);
         tick();
      end
      cnt_sel = 2'd0;
      #1;
      checks++;
      if (cnt_out !== 16'hFFFF) begin errors++; $display("FAIL cnt_ch0_max got %h exp ffff", cnt_out); end
      in_valid = 1'b0;
      tick();
      checks++;
      if (cnt_out !== 16'h0000) begin errors++; $display("FAIL cnt_ch0_wrap got %h exp 0000", cnt_out); end
      cnt_sel = 2'd1;
      #1;
      checks++;
      if (cnt_out !== 16'd3) begin errors++; $display("FAIL cnt_ch1_keep got %0d exp 3", cnt_out); end
      o_ready = 4'b0000;
`else
      o_ready = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h100 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      o_ready = 4'b0000;
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1;
         checks++;
         if (cnt_out !== 16'h0) begin errors++; $display("FAIL cnt_off[%0d] got %h exp 0", s, cnt_out); end
      end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_full_block();
      test_stream();
      test_back_to_back();
      test_async_reset();
      test_counter();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux1t4_32_buf.md
Name: demux1t4_32_buf

Overview:
- Registered 1-to-4 demultiplexer for 32-bit words; the distribution counterpart of the 4:1 selector used on the datapath.
- Accepts one word per cycle on a valid/ready input stream and steers it, by a 2-bit select, to one of four output channels.
- Each output channel has a one-deep holding register with its own valid/ready handshake.
- Sits between a single producer (e.g. the bus write path) and four consumers (peripheral/register-bank ports).

Parameters:
- DW, 32, data width of every channel.
- CW, 16, width of each per-channel transfer counter (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; asynchronous assert, active-low. One clock domain.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can take the word this cycle.
- in_sel  input  2  destination channel 0..3; sampled with in_data.
- in_data  input  DW  word to route.
- o_valid  output  4  bit k: channel k holds a word.
- o_ready  input  4  bit k: consumer k takes the word this cycle.
- o_data0  output  DW  channel 0 held word.
- o_data1  output  DW  channel 1 held word.
- o_data2  output  DW  channel 2 held word.
- o_data3  output  DW  channel 3 held word.
- cnt_sel  input  2  selects which channel's counter drives cnt_out.
- cnt_out  output  CW  transfer count of channel cnt_sel (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): o_valid=4'b0000, o_data0..3=0, all counters=0, cnt_out=0. in_ready is combinational and equals 1 while in reset, since no channel is full.
- Per channel k: storage d_k (DW bits) and flag v_k. o_valid[k]=v_k and o_data_k=d_k, both driven from registers.
- in_ready = ~v[in_sel] | o_ready[in_sel]. It is combinational and depends only on the addressed channel.
  - A full channel does not block traffic to the other channels.
  - A full channel being drained in the same cycle accepts a new word (pass-through, no bubble).
- acc_k = in_valid & in_ready & (in_sel==k).
- drn_k = v_k & o_ready[k].
- Channel update at the clock edge:
  - acc_k: d_k<=in_data, v_k<=1. This also covers acc_k & drn_k in the same cycle: back-to-back words, full throughput.
  - else drn_k: v_k<=0, d_k holds its value.
  - else: hold.
- Latency: a word accepted at edge N appears on o_data_k / o_valid[k] after edge N. It is consumed at the first later edge where o_ready[k]=1.
- Ordering is preserved per channel. No ordering guarantee across channels.
- o_ready[k] while v_k=0 is ignored.
- in_valid=0: no state change apart from drains.
- Stability: while v_k=1 and o_ready[k]=0, d_k is unchanged for any in_* activity.
- Producer contract: while in_valid=1 and in_ready=0, hold in_sel/in_data. The block does not check this.
- Reset mid-operation clears all held words. Words in flight are lost, with no partial state.
- Throughput: 1 word/cycle when the consumers keep up. At most 4 words buffered in total, 1 per channel.

Optional Feature:
- Macro: DEMUX1T4_CNT_EN.
- Defined:
  - Four CW-bit counters; cnt_k increments on each drn_k.
  - The counters wrap modulo 2^CW: 16'hFFFF+1 -> 16'h0000.
  - cnt_out = cnt[cnt_sel], combinational mux of registers.
  - Counters clear only on reset.
- Not defined: no counter flops; cnt_out tied to 0; cnt_sel ignored.

Test Plan:
- Reset, then in_valid=1, in_sel=2, in_data=32'hDEADBEEF, o_ready=4'b0000 -> in_ready=1; next cycle o_valid=4'b0100, o_data2=32'hDEADBEEF, others 0.
- Channel 2 full, o_ready=0, send in_sel=2, in_data=32'h12345678 -> in_ready=0, o_data2 stays 32'hDEADBEEF. Same cycle, in_sel=1, data 32'hA5A5A5A5 -> accepted, o_valid=4'b0110.
- Channel 0 streaming: o_ready[0]=1 held, 8 consecutive words 1..8 on in_sel=0 -> in_ready=1 every cycle; o_data0 shows 1..8 on consecutive cycles, no bubbles.
- Simultaneous drain and fill on channel 3 (v_3=1, o_ready[3]=1, in_sel=3, data 32'h0000_0055) -> v_3 stays 1, o_data3=32'h0000_0055 next cycle.
- Assert rst_n=0 mid-cycle with o_valid=4'b1111 -> o_valid=0 and o_data*=0 immediately, without waiting for clk.
- With DEMUX1T4_CNT_EN: 3 drains on channel 1, cnt_sel=1 -> cnt_out=3. Preload 65535 drains on channel 0 plus 1 more -> cnt_out=0 for cnt_sel=0. Without the macro: cnt_out=0 always.
